// File: rtl/mmio_timer_responder_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets,
// CTRL/STATUS bit positions and reset values.
package mmio_timer_responder_pkg;

   // Register index (bus_addr[4:2])
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_COMPARE  = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;

   // CTRL bit positions
   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_ONE_SHOT    = 2;
   localparam int CTRL_IRQ_EN      = 3;

   // STATUS bit positions
   localparam int STAT_MATCH = 0;
   localparam int STAT_OVF   = 1;

   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_responder_timer_prescaler.sv
// Prescaler: free-running divider that pulses tick once every presc+1
// enabled cycles. clr restarts the divide from zero.
module timer_prescaler #(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   input  logic               clr,
   output logic               tick
);

   logic [PRESC_W-1:0] presc_cnt;

   // tick is decided on the current count so it lines up with the cycle
   // in which the counter wraps back to zero
   assign tick = en & (presc_cnt == presc);

   // divider counter; holds while disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       presc_cnt <= '0;
      else if (clr)  presc_cnt <= '0;
      else if (en)   presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
   end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer responder: address decode, register file,
// prescaled up-counter with compare/overflow and a level interrupt.
module mmio_timer_responder
   import mmio_timer_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_F100,
   parameter int          PRESC_W   = 16
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        bus_en,
   input  logic        bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_hit,
   output logic        irq
);

   logic [3:0]         ctrl;
   logic [PRESC_W-1:0] prescale;
   logic [31:0]        count;
   logic [31:0]        compare;
   logic [1:0]         status;

   logic [2:0] idx;
   logic       wr;
   logic       tick;
   logic       match;
   logic       wrap;
   logic [1:0] stat_set;
   logic [1:0] stat_clr;

   // Decode: the word-aligned check keeps the idle address 0xFFFF_FFFF out
   assign bus_hit = bus_en & (bus_addr[31:5] == BASE_ADDR[31:5]) & (bus_addr[1:0] == 2'b00);
   assign idx     = bus_addr[4:2];
   assign wr      = bus_hit & bus_we;

   timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (cpu_clk),
      .rst   (cpu_rst),
      .en    (ctrl[CTRL_EN]),
      .presc (prescale),
      .clr   (wr && (idx == REG_PRESCALE)),
      .tick  (tick)
   );

   assign match    = tick & (count == compare);
   assign wrap     = tick & (count == 32'hFFFF_FFFF);
   assign stat_set = {wrap, match};
   assign stat_clr = (wr && (idx == REG_STATUS)) ? bus_wdata[1:0] : 2'b00;

   // irq only depends on registered state
   assign irq = status[STAT_MATCH] & ctrl[CTRL_IRQ_EN];

   // Register file and counter; CPU writes override same-cycle tick updates,
   // hardware status sets override same-cycle W1C
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         ctrl     <= '0;
         prescale <= '0;
         count    <= '0;
         compare  <= COMPARE_RST;
         status   <= '0;
      end else begin
         if (wr && (idx == REG_CTRL))
            ctrl <= bus_wdata[3:0];
         else if (match && ctrl[CTRL_ONE_SHOT])
            ctrl[CTRL_EN] <= 1'b0;

         if (wr && (idx == REG_COUNT))
            count <= bus_wdata;
         else if (tick)
            // a match+wrap coincidence lands on 0 either way
            count <= (match && ctrl[CTRL_AUTO_RELOAD]) ? 32'd0 : count + 32'd1;

         if (wr && (idx == REG_PRESCALE)) prescale <= bus_wdata[PRESC_W-1:0];
         if (wr && (idx == REG_COMPARE))  compare  <= bus_wdata;

         status <= (status & ~stat_clr) | stat_set;
      end
   end

   // Combinational read mux; zero unless this is a load hitting the window
   always_comb begin
      bus_rdata = '0;
      if (bus_hit && !bus_we) begin
         case (idx)
            REG_CTRL:     bus_rdata = {28'd0, ctrl};
            REG_PRESCALE: bus_rdata = 32'(prescale);
            REG_COUNT:    bus_rdata = count;
            REG_COMPARE:  bus_rdata = compare;
            REG_STATUS:   bus_rdata = {30'd0, status};
            default:      bus_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Bench for mmio_timer_responder: directed scenarios plus random bus
// traffic, all compared against a behavioural model of the register map.
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE = 32'hFFFF_F100;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        bus_en, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_hit, irq;

   int errors = 0;
   int checks = 0;

   mmio_timer_responder #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .bus_en    (bus_en),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_hit   (bus_hit),
      .irq       (irq)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit        m_en, m_auto, m_one, m_ie;
   int unsigned m_presc, m_pcnt;
   bit [31:0] m_count, m_cmp;
   bit        m_match, m_ovf;

   task automatic m_reset();
      {m_en, m_auto, m_one, m_ie} = 4'b0;
      m_presc = 0; m_pcnt = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
      m_match = 0; m_ovf = 0;
   endtask

   function automatic bit m_hit(input bit en, input bit [31:0] a);
      return en && (a >= BASE) && (a < BASE + 32) && (a % 4 == 0);
   endfunction

   function automatic bit [31:0] m_read(input bit en, input bit we, input bit [31:0] a);
      if (!m_hit(en, a) || we) return 0;
      case ((a - BASE) / 4)
         0: return {m_ie, m_one, m_auto, m_en};
         1: return m_presc;
         2: return m_count;
         3: return m_cmp;
         4: return {m_ovf, m_match};
         default: return 0;
      endcase
   endfunction

   // one clock edge of the timer, as described by its rules
   task automatic m_edge(input bit en, input bit we, input bit [31:0] a, input bit [31:0] d);
      bit tick, mt, ov, w;
      int unsigned reg_i;
      bit [31:0] nc; bit nen; int unsigned npc;
      if (cpu_rst) begin m_reset(); return; end
      tick = m_en && (m_pcnt == m_presc);
      mt   = tick && (m_count == m_cmp);
      ov   = tick && (m_count == 32'hFFFF_FFFF);
      nc   = m_count; nen = m_en; npc = m_pcnt;
      if (m_en) npc = tick ? 0 : m_pcnt + 1;
      if (tick) nc = (mt && m_auto) ? 0 : m_count + 1;
      if (mt && m_one) nen = 0;
      w = m_hit(en, a) && we;
      reg_i = (a - BASE) / 4;
      if (w && reg_i == 0) {m_ie, m_one, m_auto, nen} = d[3:0];
      if (w && reg_i == 1) begin m_presc = d[15:0]; npc = 0; end
      if (w && reg_i == 2) nc = d;
      if (w && reg_i == 3) m_cmp = d;
      if (w && reg_i == 4) begin
         if (d[0]) m_match = 0;
         if (d[1]) m_ovf = 0;
      end
      if (mt) m_match = 1;
      if (ov) m_ovf = 1;
      m_en = nen; m_count = nc; m_pcnt = npc;
   endtask

   // ---------------- bus driver ----------------
   task automatic cyc(input bit en, input bit we, input bit [31:0] a, input bit [31:0] d,
                      output logic [31:0] obs);
      @(negedge cpu_clk);
      bus_en = en; bus_we = we; bus_addr = a; bus_wdata = d;
      #1;
      obs = bus_rdata;
      chk("hit", {31'd0, bus_hit}, {31'd0, m_hit(en, a)});
      chk("rdata", bus_rdata, m_read(en, we, a));
      @(posedge cpu_clk);
      m_edge(en, we, a, d);
      #1;
      chk("irq", {31'd0, irq}, {31'd0, m_match & m_ie});
   endtask

   task automatic wr(input int r, input bit [31:0] d);
      logic [31:0] o;
      cyc(1, 1, BASE + 4 * r, d, o);
   endtask

   task automatic rd(input int r, output logic [31:0] v);
      cyc(1, 0, BASE + 4 * r, 0, v);
   endtask

   task automatic idle(input int n);
      logic [31:0] o;
      for (int i = 0; i < n; i++) cyc(1, 0, 32'hFFFF_FFFF, 0, o);
   endtask

   initial begin
      logic [31:0] v;
      int k;
      bus_en = 0; bus_we = 0; bus_addr = 32'hFFFF_FFFF; bus_wdata = 0;
      cpu_rst = 1; m_reset();
      #12; #1;
      chk("rst_irq", {31'd0, irq}, 0);
      @(negedge cpu_clk); cpu_rst = 0;

      // reset values
      rd(3, v); chk("rst_compare", v, 32'hFFFF_FFFF);
      rd(0, v); chk("rst_ctrl", v, 0);

      // idle and misaligned accesses never hit
      cyc(1, 1, 32'hFFFF_FFFF, 32'h1234, v);
      cyc(1, 1, BASE + 1, 32'hF, v);
      cyc(1, 0, BASE + 1, 0, v); chk("misalign_rd", v, 0);
      cyc(0, 0, BASE, 0, v); chk("noen_rd", v, 0);
      rd(0, v); chk("ctrl_untouched", v, 0);

      // auto-reload with prescale 3, compare 5
      wr(1, 3); wr(3, 5); wr(0, 4'b1011);
      k = 0;
      while (!irq && k < 40) begin idle(1); k++; end
      chk("irq_timeout", {31'd0, irq}, 1);
      rd(4, v); chk("match_set", v & 1, 1);
      wr(4, 1);
      chk("irq_cleared", {31'd0, irq}, 0);
      wr(0, 0);

      // wrap to zero then match at zero
      wr(4, 3); wr(2, 32'hFFFF_FFFE); wr(1, 0); wr(3, 0); wr(0, 1);
      idle(2);
      rd(4, v); chk("ovf_only", v, 2);
      rd(4, v); chk("ovf_match", v, 3);
      wr(0, 0); wr(4, 3);

      // one-shot stops after the match
      wr(2, 0); wr(1, 0); wr(3, 2); wr(0, 4'b0101);
      idle(5);
      rd(2, v); chk("oneshot_count", v, 3);
      rd(0, v); chk("oneshot_ctrl", v, 4'b0100);
      wr(4, 3);

      // W1C vs set, and COUNT write vs tick
      wr(1, 0); wr(3, 0); wr(2, 0); wr(0, 4'b0011);
      wr(4, 1);
      rd(4, v); chk("w1c_loses", v & 1, 1);
      wr(2, 100);
      rd(2, v); chk("cnt_wr_wins", v, 100);
      wr(0, 0); wr(4, 3);

      // asynchronous reset mid-count
      wr(1, 9); wr(3, 32'hFFFF_FFFF); wr(2, 7); wr(0, 4'b1001);
      idle(3);
      @(negedge cpu_clk); #2;
      cpu_rst = 1; m_reset(); #1;
      chk("rst_mid_irq", {31'd0, irq}, 0);
      rd(3, v); chk("rst_mid_cmp", v, 32'hFFFF_FFFF);
      rd(2, v); chk("rst_mid_cnt", v, 0);
      rd(0, v); chk("rst_mid_ctrl", v, 0);
      @(negedge cpu_clk); cpu_rst = 0;

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         bit [31:0] a, d;
         int r, sel;
         sel = $urandom_range(0, 9);
         r = $urandom_range(0, 7);
         if (sel < 7)       a = BASE + 4 * r;
         else if (sel == 7) a = BASE + 4 * r + $urandom_range(1, 3);
         else if (sel == 8) a = 32'hFFFF_FFFF;
         else               a = $urandom;
         case (r)
            0: d = $urandom_range(0, 15);
            1: d = $urandom_range(0, 3);
            2: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                              : $urandom_range(0, 20);
            3: d = $urandom_range(0, 20);
            default: d = $urandom;
         endcase
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, a, d, v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
